// File: rtl/mvu_control_unit_if.sv
// Handshake/datapath bundle between the MVU sequencer, its activation source and the PE/SIMD array.
// master = sequencer side, slave = source/datapath side.
interface mvu_control_unit_if #(
   parameter int SIMD = 2,
   parameter int TI   = 1,
   parameter int WA   = 2
);
   logic                 in_v;
   logic                 in_rdy;
   logic [SIMD*TI-1:0]   in_act;
   logic                 out_rdy;
   logic                 beat_v;
   logic [SIMD*TI-1:0]   act_out;
   logic [WA-1:0]        wgt_addr;
   logic                 beat_first;
   logic                 beat_last;
   logic                 busy;

   modport master (
      input  in_v, in_act, out_rdy,
      output in_rdy, beat_v, act_out, wgt_addr, beat_first, beat_last, busy
   );

   modport slave (
      output in_v, in_act, out_rdy,
      input  in_rdy, beat_v, act_out, wgt_addr, beat_first, beat_last, busy
   );
endinterface

// File: rtl/mvu_control_unit.sv
// MVU sequencer: captures one input vector (SF beats) while forwarding it, then replays it for the
// remaining NF-1 neuron folds. Define MVU_CTRL_PERF_EN to add saturating beat/stall counters.
module mvu_control_unit #(
   parameter int SIMD    = 2,
   parameter int PE      = 2,
   parameter int TI      = 1,
   parameter int MATRIXW = 4,
   parameter int MATRIXH = 4
) (
   input  logic               clk,
   input  logic               rst,
   mvu_control_unit_if.master bus
`ifdef MVU_CTRL_PERF_EN
   ,
   output logic [31:0]        perf_beats,
   output logic [31:0]        perf_stalls
`endif
);
   localparam int SF = MATRIXW / SIMD;
   localparam int NF = MATRIXH / PE;
   localparam int WA = (SF * NF > 1) ? $clog2(SF * NF) : 1;
   localparam int SA = (SF > 1) ? $clog2(SF) : 1;
   localparam int NA = (NF > 1) ? $clog2(NF) : 1;
   localparam int W  = SIMD * TI;

   typedef enum logic {
      FILL,
      REPLAY
   } state_t;

   state_t        state_reg, state_next;
   logic [SA-1:0] sf_reg, sf_next;
   logic [NA-1:0] nf_reg, nf_next;

   logic          stall;
   logic          in_fill;
   logic          accept;
   logic          issue;
   logic          sf_wrap;
   logic          nf_wrap;

   // Power-of-two depth keeps every sf index in range, including SF==1.
   logic [W-1:0]  buf_mem [2**SA];

   logic          beat_v_reg;
   logic [W-1:0]  act_out_reg;
   logic [WA-1:0] wgt_addr_reg;
   logic          beat_first_reg;
   logic          beat_last_reg;

   assign stall   = !bus.out_rdy;
   assign in_fill = (state_reg == FILL);
   assign accept  = in_fill && bus.in_v && !stall;
   assign issue   = in_fill ? accept : !stall;
   assign sf_wrap = (sf_reg == SA'(SF - 1));
   assign nf_wrap = (nf_reg == NA'(NF - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= FILL;
         sf_reg    <= '0;
         nf_reg    <= '0;
      end else begin
         state_reg <= state_next;
         sf_reg    <= sf_next;
         nf_reg    <= nf_next;
      end
   end

   // Last beat of the last fold returns to FILL; with NF==1 that is the end of the fill itself.
   always_comb begin
      state_next = state_reg;
      sf_next    = sf_reg;
      nf_next    = nf_reg;
      if (issue) begin
         if (sf_wrap) begin
            sf_next = '0;
            if (nf_wrap) begin
               nf_next    = '0;
               state_next = FILL;
            end else begin
               nf_next    = nf_reg + NA'(1);
               state_next = REPLAY;
            end
         end else begin
            sf_next = sf_reg + SA'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         buf_mem[sf_reg] <= bus.in_act;
      end
   end

   // The buffer read lands in the same register as the fill bypass, so both paths have one cycle of latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_v_reg     <= 1'b0;
         act_out_reg    <= '0;
         wgt_addr_reg   <= '0;
         beat_first_reg <= 1'b0;
         beat_last_reg  <= 1'b0;
      end else begin
         beat_v_reg <= issue;
         if (issue) begin
            act_out_reg    <= in_fill ? bus.in_act : buf_mem[sf_reg];
            wgt_addr_reg   <= WA'(nf_reg) * WA'(SF) + WA'(sf_reg);
            beat_first_reg <= (sf_reg == '0);
            beat_last_reg  <= sf_wrap;
         end
      end
   end

   assign bus.in_rdy     = in_fill && !stall;
   assign bus.busy       = (state_reg == REPLAY) || (sf_reg != '0);
   assign bus.beat_v     = beat_v_reg;
   assign bus.act_out    = act_out_reg;
   assign bus.wgt_addr   = wgt_addr_reg;
   assign bus.beat_first = beat_first_reg;
   assign bus.beat_last  = beat_last_reg;

`ifdef MVU_CTRL_PERF_EN
   logic [31:0] perf_beats_reg;
   logic [31:0] perf_stalls_reg;

   // A stall only counts when work was actually being held back.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_beats_reg  <= '0;
         perf_stalls_reg <= '0;
      end else begin
         if (issue && (perf_beats_reg != 32'hFFFF_FFFF)) begin
            perf_beats_reg <= perf_beats_reg + 32'd1;
         end
         if (stall && (!in_fill || bus.in_v) && (perf_stalls_reg != 32'hFFFF_FFFF)) begin
            perf_stalls_reg <= perf_stalls_reg + 32'd1;
         end
      end
   end

   assign perf_beats  = perf_beats_reg;
   assign perf_stalls = perf_stalls_reg;
`endif
endmodule

// File: tb/tb_mvu_control_unit.sv
// Bench for mvu_control_unit: default build (SF=2, NF=2) plus an SF=1/NF=1 instance on the same stimulus,
// checked against a vector-level model of fill, replay and stall behaviour.
module tb_mvu_control_unit;
   localparam int SIMD = 2;
   localparam int PE   = 2;
   localparam int TI   = 1;
   localparam int MW   = 4;
   localparam int MH   = 4;
   localparam int SF   = MW / SIMD;
   localparam int NF   = MH / PE;
   localparam int W    = SIMD * TI;
   localparam int WA   = 2;

   logic clk;
   logic rst;

   mvu_control_unit_if #(.SIMD(SIMD), .TI(TI), .WA(WA)) bus ();
   mvu_control_unit_if #(.SIMD(1), .TI(1), .WA(1))      bus1 ();

   assign bus1.in_v    = bus.in_v;
   assign bus1.in_act  = bus.in_act[0];
   assign bus1.out_rdy = bus.out_rdy;

`ifdef MVU_CTRL_PERF_EN
   logic [31:0] perf_beats, perf_stalls, perf1_beats, perf1_stalls;
`endif

   mvu_control_unit #(.SIMD(SIMD), .PE(PE), .TI(TI), .MATRIXW(MW), .MATRIXH(MH)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef MVU_CTRL_PERF_EN
      ,
      .perf_beats(perf_beats),
      .perf_stalls(perf_stalls)
`endif
   );

   mvu_control_unit #(.SIMD(1), .PE(2), .TI(1), .MATRIXW(1), .MATRIXH(2)) dut1 (
      .clk(clk),
      .rst(rst),
      .bus(bus1)
`ifdef MVU_CTRL_PERF_EN
      ,
      .perf_beats(perf1_beats),
      .perf_stalls(perf1_stalls)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Model: position within the SF*NF-beat vector schedule, the stored vector, and the expected output registers.
   int           pos;
   logic [W-1:0] vec [SF];
   logic         e_v, e_first, e_last;
   logic [W-1:0] e_act;
   int           e_addr;
   logic         e1_v, e1_act, e1_fl;
   int           e_pb, e_ps;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs();
      chk("beat_v",     32'(bus.beat_v),     32'(e_v));
      chk("act_out",    32'(bus.act_out),    32'(e_act));
      chk("wgt_addr",   32'(bus.wgt_addr),   32'(e_addr));
      chk("beat_first", 32'(bus.beat_first), 32'(e_first));
      chk("beat_last",  32'(bus.beat_last),  32'(e_last));
      chk("sf1_beat_v", 32'(bus1.beat_v),    32'(e1_v));
      chk("sf1_act",    32'(bus1.act_out),   32'(e1_act));
      chk("sf1_addr",   32'(bus1.wgt_addr),  32'd0);
      chk("sf1_first",  32'(bus1.beat_first), 32'(e1_fl));
      chk("sf1_last",   32'(bus1.beat_last),  32'(e1_fl));
`ifdef MVU_CTRL_PERF_EN
      chk("perf_beats",  perf_beats,  32'(e_pb));
      chk("perf_stalls", perf_stalls, 32'(e_ps));
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_v = 1'b0;
      bus.in_act = '0;
      bus.out_rdy = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      pos = 0;
      e_v = 1'b0; e_act = '0; e_addr = 0; e_first = 1'b0; e_last = 1'b0;
      e1_v = 1'b0; e1_act = 1'b0; e1_fl = 1'b0;
      e_pb = 0; e_ps = 0;
      $display("reset");
      chk_outputs();
      chk("rst_busy",     32'(bus.busy),   32'd0);
      chk("rst_in_rdy",   32'(bus.in_rdy), 32'd1);
      chk("rst_sf1_busy", 32'(bus1.busy),  32'd0);
   endtask

   task automatic step(input logic v, input logic [W-1:0] a, input logic ordy);
      logic iss, iss1;
      int   sfv;
      bus.in_v    = v;
      bus.in_act  = a;
      bus.out_rdy = ordy;
      #1;
      chk("in_rdy",     32'(bus.in_rdy),  32'(ordy && (pos < SF)));
      chk("busy",       32'(bus.busy),    32'(pos != 0));
      chk("sf1_in_rdy", 32'(bus1.in_rdy), 32'(ordy));
      chk("sf1_busy",   32'(bus1.busy),   32'd0);
      iss = (pos < SF) ? (v && ordy) : ordy;
      if (!ordy && ((pos >= SF) || v)) e_ps++;
      if (iss) begin
         sfv = pos % SF;
         if (pos < SF) vec[sfv] = a;
         e_act   = vec[sfv];
         e_addr  = pos;
         e_first = (sfv == 0);
         e_last  = (sfv == SF - 1);
         pos     = (pos + 1) % (SF * NF);
         e_pb++;
      end
      e_v  = iss;
      iss1 = v && ordy;
      e1_v = iss1;
      if (iss1) begin
         e1_act = a[0];
         e1_fl  = 1'b1;
      end
      @(posedge clk);
      #1;
      $display("step in_v=%0b act=%0h out_rdy=%0b -> beat_v=%0b act=%0h addr=%0d first=%0b last=%0b",
               v, a, ordy, bus.beat_v, bus.act_out, bus.wgt_addr, bus.beat_first, bus.beat_last);
      chk_outputs();
   endtask

   initial begin
      rst = 1'b1;
      bus.in_v = 1'b0;
      bus.in_act = '0;
      bus.out_rdy = 1'b1;
      do_reset();

      // One vector: two fills then two replays, then idle.
      step(1'b1, W'($urandom), 1'b1);
      step(1'b1, W'($urandom), 1'b1);
      step(1'b1, W'($urandom), 1'b1);
      step(1'b1, W'($urandom), 1'b1);
      step(1'b0, '0, 1'b1);

      // in_v held high across two vectors.
      repeat (8) step(1'b1, W'($urandom), 1'b1);
      step(1'b0, '0, 1'b1);

      // Back-pressure during replay after the addr-2 beat.
      step(1'b1, W'($urandom), 1'b1);
      step(1'b1, W'($urandom), 1'b1);
      step(1'b1, W'($urandom), 1'b1);
      repeat (3) step(1'b1, W'($urandom), 1'b0);
      step(1'b1, W'($urandom), 1'b1);
      step(1'b0, '0, 1'b1);

      // Reset right after the first beat of a vector is accepted.
      step(1'b1, W'($urandom), 1'b1);
      do_reset();
      repeat (4) step(1'b1, W'($urandom), 1'b1);

      // Randomized valid, data and back-pressure.
      repeat (300) step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0);

      // One vector with three stalled replay cycles.
      do_reset();
      step(1'b1, W'($urandom), 1'b1);
      step(1'b1, W'($urandom), 1'b1);
      step(1'b0, '0, 1'b1);
      repeat (3) step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
`ifdef MVU_CTRL_PERF_EN
      chk("perf_beats_vec",  perf_beats,  32'd4);
      chk("perf_stalls_vec", perf_stalls, 32'd3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
